// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - N-master AXI read-port arbiter with per-rid return routing
// Optional AXI_RD_ARB_PRIO0_EN: master 0 wins whenever eligible, others round-robin.
module axi_rd_arbiter #(
   parameter int N_MST  = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [N_MST*ADDR_W-1:0]   m_araddr,
   input  logic [N_MST*8-1:0]        m_arlen,
   input  logic [N_MST*3-1:0]        m_arsize,
   input  logic [N_MST*2-1:0]        m_arburst,
   input  logic [N_MST-1:0]          m_arvalid,
   output logic [N_MST-1:0]          m_arready,
   output logic [N_MST*DATA_W-1:0]   m_rdata,
   output logic [N_MST*2-1:0]        m_rresp,
   output logic [N_MST-1:0]          m_rlast,
   output logic [N_MST-1:0]          m_rvalid,
   input  logic [N_MST-1:0]          m_rready,
   output logic [3:0]                arid,
   output logic [ADDR_W-1:0]         araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic [1:0]                arlock,
   output logic [3:0]                arcache,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [3:0]                rid,
   input  logic [DATA_W-1:0]         rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic                      err_badid
);

   localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     winner;
   logic [GW-1:0]     cand;
   logic [GW-1:0]     rsel;
   logic [N_MST-1:0]  outstanding;
   logic [N_MST-1:0]  elig;
   logic [N_MST-1:0]  grant_oh;
   logic [N_MST-1:0]  set_vec;
   logic [N_MST-1:0]  clr_vec;
   logic              found;
   logic              bad_id;
   logic              r_done;

   assign elig = m_arvalid & ~outstanding;

   // Rotating search starting just after the previous winner.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < N_MST; k++) begin
         cand = GW'((int'(last_grant) + 1 + k) % N_MST);
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`ifdef AXI_RD_ARB_PRIO0_EN
      if (elig[0]) begin
         found  = 1'b1;
         winner = '0;
      end
`endif
   end

   assign grant_oh  = found ? (N_MST'(1) << winner) : '0;
   assign m_arready = (state == IDLE && !areset) ? grant_oh : '0;
   assign set_vec   = (state == IDLE) ? grant_oh : '0;

   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   assign bad_id = (rid >= 4'(N_MST));
   assign rsel   = rid[GW-1:0];

   // Unknown ids are swallowed so the slave never stalls on them.
   always_comb begin
      m_rvalid = '0;
      m_rlast  = '0;
      rready   = 1'b1;
      m_rdata  = {N_MST{rdata}};
      m_rresp  = {N_MST{rresp}};
      if (!bad_id) begin
         m_rvalid[rsel] = rvalid;
         m_rlast[rsel]  = rlast;
         rready         = m_rready[rsel];
      end
   end

   assign r_done  = rvalid & rready & rlast & ~bad_id;
   assign clr_vec = r_done ? (N_MST'(1) << rsel) : '0;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= IDLE;
         arvalid     <= 1'b0;
         outstanding <= '0;
         last_grant  <= GW'(N_MST - 1);
         err_badid   <= 1'b0;
         arid        <= '0;
         araddr      <= '0;
         arlen       <= '0;
         arsize      <= '0;
         arburst     <= '0;
      end else begin
         outstanding <= (outstanding & ~clr_vec) | set_vec;
         if (rvalid && bad_id)
            err_badid <= 1'b1;
         case (state)
            IDLE: begin
               if (found) begin
                  arid       <= 4'(winner);
                  araddr     <= m_araddr[winner*ADDR_W +: ADDR_W];
                  arlen      <= m_arlen[winner*8 +: 8];
                  arsize     <= m_arsize[winner*3 +: 3];
                  arburst    <= m_arburst[winner*2 +: 2];
                  last_grant <= winner;
                  arvalid    <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
